// File: rtl/nes_pad_responder_if.sv
// Host/pad signal bundle for the NES serial pad link.
// The host drives the strobes and the live button state. The pad answers with serial data and status.
interface nes_pad_responder_if;
  logic       latch_in;
  logic       pulse_in;
  logic [7:0] buttons;
  logic       data_out;
  logic       frame_done;
  logic [7:0] poll_count;

  modport master (
    output latch_in,
    output pulse_in,
    output buttons,
    input  data_out,
    input  frame_done,
    input  poll_count
  );

  modport slave (
    input  latch_in,
    input  pulse_in,
    input  buttons,
    output data_out,
    output frame_done,
    output poll_count
  );
endinterface

// File: rtl/nes_pad_responder.sv
// Pad-side responder for the NES serial pad protocol, modelled on a 4021 shift register.
// The latch strobe captures the buttons, and each pulse rising edge shifts out the next bit.
module nes_pad_responder #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit FILL_BIT   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  nes_pad_responder_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] latch_sync_r;   // [0],[1] synchronizer, [2] previous synchronized value
  logic [2:0] pulse_sync_r;
  logic [7:0] sr_r, sr_s;
  logic [3:0] cnt_r, cnt_s;
  logic       frame_done_r, frame_done_s;
  logic [7:0] poll_count_r, poll_count_s;
  logic       latch_level_s, latch_fall_s, pulse_rise_s;

  assign latch_level_s = latch_sync_r[1];
  assign latch_fall_s  = ~latch_sync_r[1] & latch_sync_r[2];
  assign pulse_rise_s  = pulse_sync_r[1] & ~pulse_sync_r[2];

  // Synchronize the host strobes and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_sync_r <= 3'b000;
      pulse_sync_r <= 3'b000;
    end else begin
      latch_sync_r <= {latch_sync_r[1:0], bus.latch_in};
      pulse_sync_r <= {pulse_sync_r[1:0], bus.pulse_in};
    end
  end

  // State, shift register, counters and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      sr_r         <= 8'h00;
      cnt_r        <= 4'd0;
      frame_done_r <= 1'b0;
      poll_count_r <= 8'd0;
    end else begin
      state_r      <= state_s;
      sr_r         <= sr_s;
      cnt_r        <= cnt_s;
      frame_done_r <= frame_done_s;
      poll_count_r <= poll_count_s;
    end
  end

  // Next-state logic; a high latch overrides everything and discards any same-cycle shift
  always_comb begin
    state_s      = state_r;
    sr_s         = sr_r;
    cnt_s        = cnt_r;
    frame_done_s = 1'b0;
    poll_count_s = poll_count_r;
    if (latch_level_s) begin
      state_s = LOAD;
      sr_s    = bus.buttons;
      cnt_s   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        LOAD: begin
          if (latch_fall_s) begin
            state_s      = SHIFT;
            poll_count_s = poll_count_r + 8'd1;
          end else begin
            state_s = LOAD;
          end
        end
        SHIFT: begin
          if (pulse_rise_s) begin
            sr_s  = {FILL_BIT, sr_r[7:1]};
            cnt_s = cnt_r + 4'd1;
            if (cnt_r == 4'd7) begin
              state_s      = DONE;
              frame_done_s = 1'b1;
            end else begin
              state_s = SHIFT;
            end
          end else begin
            state_s = SHIFT;
          end
        end
        DONE: begin
          if (pulse_rise_s) begin
            sr_s = {FILL_BIT, sr_r[7:1]};
          end else begin
            sr_s = sr_r;
          end
          cnt_s = 4'd8;
        end
        default: begin
          state_s = IDLE;
          sr_s    = 8'h00;
          cnt_s   = 4'd0;
        end
      endcase
    end
  end

  assign bus.data_out   = sr_r[0] ^ ACTIVE_LOW;
  assign bus.frame_done = frame_done_r;
  assign bus.poll_count = poll_count_r;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: frame readout, over-read, re-latch, strobe rules,
// mid-frame reset and poll counter wrap, all with hand-computed expectations.
module tb_nes_pad_responder;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   fd_count;

  nes_pad_responder_if bus ();

  nes_pad_responder #(
    .ACTIVE_LOW (1'b1),
    .FILL_BIT   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which frame_done is seen high
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_count = fd_count + 1;
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_once(input int hi, input int lo);
    bus.pulse_in = 1'b1;
    ticks(hi);
    bus.pulse_in = 1'b0;
    ticks(lo);
  endtask

  task automatic latch_once(input int hi, input int lo);
    bus.latch_in = 1'b1;
    ticks(hi);
    bus.latch_in = 1'b0;
    ticks(lo);
  endtask

  logic [7:0] exp_bits;

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    fd_count     = 0;
    reset        = 1'b1;
    bus.latch_in = 1'b0;
    bus.pulse_in = 1'b0;
    bus.buttons  = 8'h00;
    ticks(2);
    reset = 1'b0;
    ticks(1);

    check("reset_data_out",   {7'd0, bus.data_out},   8'd1);
    check("reset_poll_count", bus.poll_count,         8'd0);
    check("reset_frame_done", {7'd0, bus.frame_done}, 8'd0);

    // Pulses without a latch leave the released level on the line
    pulse_once(6, 6);
    pulse_once(6, 6);
    check("idle_pulse_data",  {7'd0, bus.data_out}, 8'd1);
    check("idle_pulse_poll",  bus.poll_count,       8'd0);

    // Full frame: A, Select, Right pressed
    bus.buttons  = 8'b1000_0101;
    bus.latch_in = 1'b1;
    ticks(2);
    check("latch_latency_2clk", {7'd0, bus.data_out}, 8'd1);
    ticks(1);
    check("latch_bit_a_3clk",   {7'd0, bus.data_out}, 8'd0);
    ticks(9);
    bus.latch_in = 1'b0;
    ticks(6);
    check("frame1_poll",  bus.poll_count,       8'd1);
    check("frame1_bit0",  {7'd0, bus.data_out}, 8'd0);

    // Serial stream after pulses 1..7: 1,0,1,1,1,1,0
    exp_bits = 8'b0011_1101;
    for (int k = 0; k < 7; k++) begin
      pulse_once(6, 6);
      check($sformatf("frame1_pulse%0d", k + 1), {7'd0, bus.data_out}, {7'd0, exp_bits[k]});
    end

    // Pulse 8: frame_done for exactly the cycle after the acting edge
    bus.pulse_in = 1'b1;
    ticks(2);
    check("pulse8_fd_early", {7'd0, bus.frame_done}, 8'd0);
    ticks(1);
    check("pulse8_fd_high",  {7'd0, bus.frame_done}, 8'd1);
    check("pulse8_fill",     {7'd0, bus.data_out},   8'd0);
    ticks(1);
    check("pulse8_fd_low",   {7'd0, bus.frame_done}, 8'd0);
    ticks(2);
    bus.pulse_in = 1'b0;
    ticks(6);

    // Over-read shifts in pressed fill bits, no further frame_done
    for (int k = 0; k < 3; k++) begin
      pulse_once(6, 6);
      check($sformatf("overread%0d", k + 1), {7'd0, bus.data_out}, 8'd0);
    end
    check("overread_fd_once", fd_count[7:0], 8'd1);
    check("overread_poll",    bus.poll_count, 8'd1);

    // All pressed, 3 pulses, then re-latch with only B pressed
    bus.buttons = 8'hFF;
    latch_once(12, 6);
    check("frame2_poll", bus.poll_count, 8'd2);
    for (int k = 0; k < 3; k++) pulse_once(6, 6);
    check("frame2_bit3", {7'd0, bus.data_out}, 8'd0);
    bus.buttons  = 8'h02;
    bus.latch_in = 1'b1;
    ticks(2);
    check("relatch_2clk", {7'd0, bus.data_out}, 8'd0);
    ticks(1);
    check("relatch_3clk", {7'd0, bus.data_out}, 8'd1);

    // Pulses while latch is high do not shift; sr keeps tracking buttons
    pulse_once(6, 6);
    check("latch_hold_pulse", {7'd0, bus.data_out}, 8'd1);
    bus.buttons = 8'h01;
    ticks(2);
    check("latch_track_a",    {7'd0, bus.data_out}, 8'd0);
    bus.buttons = 8'h02;
    ticks(2);
    check("latch_track_b",    {7'd0, bus.data_out}, 8'd1);
    bus.latch_in = 1'b0;
    ticks(6);
    check("frame3_poll",      bus.poll_count, 8'd3);
    check("aborted_no_fd",    fd_count[7:0],  8'd1);

    // A 1-clk glitch has no required response; it is applied but not checked
    bus.buttons  = 8'hFD;
    bus.pulse_in = 1'b1;
    ticks(1);
    bus.pulse_in = 1'b0;
    ticks(6);

    // Button changes during shifting do not reach the frame in flight: expect 0x02 stream
    bus.buttons = 8'h02;
    latch_once(6, 6);
    check("frame4_poll", bus.poll_count, 8'd4);
    bus.buttons = 8'hFD;
    check("frame4_bit_a", {7'd0, bus.data_out}, 8'd1);
    pulse_once(6, 6);
    check("frame4_bit_b", {7'd0, bus.data_out}, 8'd0);
    pulse_once(6, 6);
    check("frame4_bit_sel", {7'd0, bus.data_out}, 8'd1);

    // Reset mid-frame after pulse 4
    bus.buttons = 8'hFF;
    latch_once(6, 6);
    for (int k = 0; k < 4; k++) pulse_once(6, 6);
    check("prereset_data", {7'd0, bus.data_out}, 8'd0);
    reset = 1'b1;
    ticks(1);
    check("midreset_data", {7'd0, bus.data_out},   8'd1);
    check("midreset_poll", bus.poll_count,         8'd0);
    check("midreset_fd",   {7'd0, bus.frame_done}, 8'd0);
    ticks(1);
    reset = 1'b0;
    ticks(1);
    pulse_once(6, 6);
    check("postreset_idle", {7'd0, bus.data_out}, 8'd1);
    check("postreset_fd",   fd_count[7:0],        8'd1);

    // Poll counter wraps after 256 latch strobes
    for (int k = 0; k < 255; k++) latch_once(4, 4);
    check("poll_255", bus.poll_count, 8'd255);
    latch_once(4, 4);
    check("poll_wrap", bus.poll_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Controller-side responder for the NES serial pad protocol: the device that answers `controller_nes`. It takes the host's `latch` and `pulse` strobes, captures an 8-bit button state on latch and shifts it out one bit per pulse on a serial data line, the same way a 4021-based pad does. It lets the game logic be driven by a simulated or FPGA-generated pad. It also provides the stimulus end of closed-loop host/pad benches.

## Interface
- `ACTIVE_LOW`, default 1: 1 means a pressed button drives `data_out` low (real pad electrical level); 0 means pressed drives `data_out` high.
- `FILL_BIT`, default 1: logical value shifted in behind the 8 button bits. 1 means "pressed", which matches an official pad.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `latch_in` input, 1 bit: host latch strobe; asynchronous to `clk`.
- `pulse_in` input, 1 bit: host shift-clock strobe; asynchronous to `clk`.
- `buttons` input, 8 bits: live button state, 1 = pressed. Order is bit0 = A, bit1 = B, bit2 = Select, bit3 = Start, bit4 = Up, bit5 = Down, bit6 = Left, bit7 = Right.
- `data_out` output, 1 bit: serial button data to the host, polarity set by `ACTIVE_LOW`.
- `frame_done` output, 1 bit: one-cycle pulse when the 8th button bit has been shifted out.
- `poll_count` output, 8 bits: count of completed latch strobes (latch falling edges); wraps 255 → 0.

## Operation
- **Synchronizers:** `latch_in` and `pulse_in` each pass through a 2-FF synchronizer. A third register per signal holds the previous synchronized value for edge detection.
- **Internal state:**
  - `sr[7:0]` shift register.
  - `cnt[3:0]` bits shifted, 0..8, saturating.
  - FSM with states IDLE, LOAD, SHIFT, DONE.
- **Output:** `data_out = sr[0] XOR ACTIVE_LOW`. It depends only on registers, with no combinational path from inputs.
- **IDLE** (after reset):
  - `sr` holds all-released (8'h00); nothing shifts.
  - Synchronized latch high → LOAD.
- **LOAD:**
  - While synchronized latch is high, `sr <= buttons` every cycle and `cnt <= 0`.
  - Pulse edges in this state are ignored (parallel-load mode).
  - Synchronized latch falling edge → `sr` frozen, `poll_count` increments, go to SHIFT.
- **SHIFT:** on each synchronized pulse rising edge:
  - `sr <= {FILL_BIT, sr[7:1]}` and `cnt` increments.
  - When `cnt` goes 7 → 8: assert `frame_done` for that one cycle and go to DONE.
- **DONE:**
  - Further pulse edges keep shifting `FILL_BIT` in; `cnt` stays at 8.
  - `frame_done` is not re-asserted.
- **Latch priority:** synchronized latch high in any state (SHIFT or DONE mid-frame included) → LOAD immediately. The partial frame is abandoned, no `frame_done` is raised, and `cnt` goes to 0.
- **Simultaneous edges:** latch high and a pulse edge in the same cycle → latch wins and the shift is discarded.
- **Reset** (any state, mid-frame included), applied on the next `clk` edge:
  - `sr = 0`, `cnt = 0`, state IDLE.
  - `frame_done = 0`, `poll_count = 0`.
  - Synchronizer and edge registers = 0.
  - `data_out = ACTIVE_LOW` (released level).

## Timing
- **Reset values:** `data_out = ACTIVE_LOW`, `frame_done = 0`, `poll_count = 0`.
- **Edge latency:** an input transition first sampled at edge E0 reaches the 2nd sync FF at E1 and is acted on at E2.
  - `sr`, `cnt`, the FSM and `poll_count` update at E2.
  - `data_out` changes just after E2. This is the 3-clk response latency.
- **Minimum strobe width:** `latch_in` and `pulse_in` high and low phases must each last ≥ 3 clk periods to be seen. Shorter glitches may be missed and carry no other requirement.
- **First bit (A):** valid on `data_out` 3 clk after `latch_in` rises, and held after the latch falls. Each following bit is valid 3 clk after each `pulse_in` rise.
- **Frame length:** a full frame is 1 latch plus 8 pulses. `frame_done` is high in the cycle after the edge that shifted out bit 7 (Right).
- **`buttons` sampling:** changes while latch is low have no effect until the next latch.

## Test plan
- **Reset:** `reset`=1 for 2 clk, `ACTIVE_LOW`=1 → `data_out`=1, `poll_count`=0, `frame_done`=0; pulses with no latch leave `data_out`=1.
- **Full frame, ACTIVE_LOW=1:** `buttons`=8'b1000_0101 (A, Select, Right); latch 12 clk, then 8 pulses 6 clk high / 6 low.
  - Serial `data_out` after latch and pulses 1..7: 0,1,0,1,1,1,1,0.
  - `frame_done` fires once after pulse 8; `poll_count`=1.
- **Over-read:** continue with 3 more pulses → `data_out`=0 (`FILL_BIT`=1 means pressed); no further `frame_done`.
- **Re-latch mid-frame:** after 3 pulses raise latch with `buttons`=8'h02 → `data_out` = A-released = 1 within 3 clk; no `frame_done` for the aborted frame; `poll_count` increments on the latch fall.
- **Strobe rules:**
  - Pulses while latch is held high → `sr` keeps tracking `buttons` and does not shift.
  - A 1-clk `pulse_in` glitch carries no required response.
  - `buttons` changed during SHIFT → the frame still outputs the latched value.
- **Reset and wrap:** reset asserted after pulse 4 → next-edge `data_out`=1 and state IDLE. Separately, 256 latch strobes → `poll_count` wraps to 0.
